// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and registered results.
// MUL (shift-add) and SHL (one bit per cycle) iterate in BUSY; all other ops complete in one cycle.
module alu_mc #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUCntr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic [2:0]       ALUFlags
);
   localparam int CW = SHW + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;

   logic               accept, iter, last;
   logic [SHW-1:0]     sh_amt;
   logic [CW-1:0]      cnt;
   logic               op_mul, gt, eq;
   logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
   logic [WIDTH-1:0]   mplier, sh, sh_nxt;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   r1;
   logic               c1;

   assign sh_amt = B[SHW-1:0];
   assign accept = in_valid && in_ready;
   assign iter   = (ALUCntr == 3'b110) || (ALUCntr == 3'b111 && sh_amt != '0);
   assign last   = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // in_ready/out_valid are gated by reset so both read 0 while reset is held
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
            if (accept) state_nxt = iter ? BUSY : DONE;
         end
         BUSY: if (last) state_nxt = DONE;
         DONE: begin
            out_valid = !reset;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum = {1'b0, A} + {1'b0, B};
      r1  = '0;
      c1  = 1'b0;
      case (ALUCntr)
         3'b000: r1 = A & B;
         3'b001: r1 = ~B;
         3'b010: r1 = A ^ B;
         3'b011: begin r1 = sum[WIDTH-1:0]; c1 = sum[WIDTH]; end
         3'b100: begin r1 = A - B; c1 = (A < B); end
         3'b101: r1 = B;
         3'b111: r1 = A;  // only reached with a zero shift amount
         default: r1 = '0;
      endcase
   end

   assign acc_nxt = acc + (mplier[0] ? mcand : '0);
   assign sh_nxt  = sh << 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         R        <= '0;
         ALUFlags <= '0;
         cnt      <= '0;
         op_mul   <= 1'b0;
         gt       <= 1'b0;
         eq       <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         sh       <= '0;
      end else if (accept) begin
         op_mul <= (ALUCntr == 3'b110);
         gt     <= (A > B);
         eq     <= (A == B);
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         sh     <= A;
         cnt    <= (ALUCntr == 3'b110) ? CW'(WIDTH) : CW'(sh_amt);
         if (!iter) begin
            R        <= r1;
            ALUFlags <= {c1, (A > B), (A == B)};
         end
      end else if (state == BUSY) begin
         cnt    <= cnt - CW'(1);
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         sh     <= sh_nxt;
         if (last) begin
            if (op_mul) begin
               R        <= acc_nxt[WIDTH-1:0];
               ALUFlags <= {|acc_nxt[2*WIDTH-1:WIDTH], gt, eq};
            end else begin
               R        <= sh_nxt;
               ALUFlags <= {sh[WIDTH-1], gt, eq};
            end
         end
      end
   end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the next generation of the datapath ALU. It adds a configurable operand width, a valid/ready handshake on both sides, and registered results. Two iterative operations are added: shift-add multiply and single-bit-per-cycle left shift. Flag generation is fully defined and mutually exclusive. It sits between the control FSM/register file and the result write-back path, so a slow operation can stall issue without stalling the rest of the datapath.

## Interface
- WIDTH, 8, operand/result width in bits (WIDTH ≥ 2)
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- ALUCntr  in  3  opcode
- out_valid  out  1  R/ALUFlags valid
- out_ready  in  1  consumer accepts the result
- R  out  WIDTH  registered result
- ALUFlags  out  3  [2] carry, [1] greater, [0] equal

## Operation
- Opcodes:
  - 000 A&B
  - 001 ~B
  - 010 A^B
  - 011 A+B
  - 100 A−B
  - 101 B
  - 110 A*B, low WIDTH bits
  - 111 A<<B[SHW-1:0]
- An operation is accepted on the cycle where in_valid && in_ready. A, B and ALUCntr are captured at that edge; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE: opcodes 000–101, or 111 with shift amount 0.
  - IDLE → BUSY: opcode 110, or 111 with nonzero shift amount.
  - BUSY → DONE: when the iteration counter expires.
  - DONE → IDLE: when out_valid && out_ready.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- MUL: shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY. The accumulator is 2·WIDTH bits wide.
- SHL: one bit per cycle, n = B[SHW-1:0] cycles in BUSY. Upper bits of B are ignored.
- Flags are computed from the captured operands and registered together with R:
  - greater = (A > B) unsigned. equal = (A == B). Greater and equal are never both 1; both are 0 when A < B.
  - carry, ADD: bit WIDTH of the (WIDTH+1)-bit sum.
  - carry, SUB: borrow, i.e. A < B.
  - carry, MUL: OR of product bits [2·WIDTH−1:WIDTH].
  - carry, SHL: the last bit shifted out; 0 when n = 0.
  - carry, all other opcodes: 0.
- In DONE, R and ALUFlags hold stable until the handshake completes.
- reset while BUSY or DONE aborts the operation. The result is discarded and never presented.

## Timing
- Reset values:
  - Outputs during reset: in_ready = 0, out_valid = 0, R = 0, ALUFlags = 3'b000.
  - State after reset: IDLE.
  - First cycle after reset deasserts: in_ready = 1.
- Latency, measured from the acceptance edge to the first cycle with out_valid = 1:
  - Opcodes 000–101, and SHL with n = 0: 1 cycle.
  - MUL: WIDTH+1 cycles.
  - SHL with n ≠ 0: n+1 cycles.
- After the result handshake, in_ready rises the next cycle. Maximum throughput for single-cycle ops is therefore one operation per 2 cycles (accept, present).
- Outside IDLE, in_valid is ignored and nothing is queued.
- out_ready may be asserted early or held high. It has effect only in DONE.
- Arithmetic is modulo 2^WIDTH. No sign interpretation anywhere.

## Test plan
- WIDTH=8, ADD A=200, B=100, out_ready=1 → R=0x2C, ALUFlags=3'b110. out_valid exactly 1 cycle after accept; in_ready=1 the following cycle.
- SUB A=5, B=7 → R=0xFE, ALUFlags=3'b100. SUB A=9, B=9 → R=0x00, ALUFlags=3'b001.
- MUL A=15, B=17 → R=0xFF, ALUFlags=3'b000 after 9 cycles. MUL A=16, B=16 → R=0x00, ALUFlags=3'b101.
- SHL A=0x81, B=3 → R=0x08, ALUFlags=3'b010 (carry 0), latency 4. SHL A=0x81, B=0x08 → R=0x81, carry 0, latency 1.
- Backpressure: XOR A=0x0F, B=0xFF, out_ready=0 for 5 cycles with in_valid=1 and changing A/B. R=0xF0 and ALUFlags=3'b000 stay stable, in_ready=0, no new op accepted. Raise out_ready → exactly one transfer.
- Assert reset on the 4th BUSY cycle of a MUL → next cycle out_valid=0, R=0, ALUFlags=0. The aborted result never appears. A following ADD 1+1 → R=0x02, ALUFlags=3'b001.
